sum_chunk_sequencer: RTL and testbench

- Sequences a chunk-serial adder to form one N-bit sum over CC clock cycles, W = N/CC bits per cycle.
- Accepts a full operand pair on a valid/ready input handshake.
- Feeds W-bit chunks LSB-first through a single W-bit adder slice and keeps the inter-chunk carry in a flop.
- Assembles the N-bit sum and carry-out and presents them on a valid/ready output handshake.
- Sits between the operand source and the consumer of the sum, and owns the carry state that the bare chunk adder leaves to its caller.

---
 rtl/sum_chunk_sequencer_pkg.sv | 19 +
 rtl/sum_chunk_sequencer_if.sv | 26 ++
 rtl/sum_chunk_add.sv | 12 +
 rtl/sum_chunk_sequencer.sv | 115 +++++++++++
 tb/tb_sum_chunk_sequencer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/sum_chunk_sequencer_pkg.sv
// Shared types and defaults for the chunk-serial adder sequencer.
// Holds the FSM state encoding and the counter width helper.
package sum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SUM_N  = 128;
    localparam int SUM_CC = 16;

    // A single-chunk configuration still needs a one-bit counter.
    function automatic int count_width(input int cc);
        return (cc <= 1) ? 1 : $clog2(cc);
    endfunction

endpackage

// File: rtl/sum_chunk_sequencer_if.sv
// Operand/result handshake bundle between source, sequencer and consumer.
interface sum_chunk_sequencer_if
    import sum_pkg::*;
#(
    parameter int N = SUM_N
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/sum_chunk_add.sv
// Combinational W-bit adder slice with carry in and carry out.
module sum_chunk_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/sum_chunk_sequencer.sv
// Feeds an N-bit operand pair LSB-first through one W-bit adder slice over CC
// cycles, owning the inter-chunk carry, and presents the assembled sum.
module sum_chunk_sequencer
    import sum_pkg::*;
#(
    parameter int N  = SUM_N,
    parameter int CC = SUM_CC
) (
    input  logic clk,
    input  logic rst,
    sum_chunk_sequencer_if.slave bus
);
    localparam int W  = N / CC;
    localparam int CW = count_width(CC);
    localparam logic [CW-1:0] LAST = CW'(CC - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    if ((CC < 1) || ((N % CC) != 0)) begin : g_bad_cc
        $error("sum_chunk_sequencer: N must be a positive multiple of CC");
    end

    state_t         r_state;
    logic [CW-1:0]  r_count;
    logic           r_carry;
    logic [N-1:0]   r_a_sh;
    logic [N-1:0]   r_b_sh;
    logic [N-1:0]   r_sum_sh;
    logic [N-1:0]   r_sum;
    logic           r_cout;
    logic           r_in_ready;
    logic           r_out_valid;
    logic           r_busy;

    logic [W-1:0]   w_res;
    logic           w_cout;
    logic [N-1:0]   w_sum_next;

    sum_chunk_add #(.W(W)) u_add (
        .a    (r_a_sh[W-1:0]),
        .b    (r_b_sh[W-1:0]),
        .cin  (r_carry),
        .s    (w_res),
        .cout (w_cout)
    );

    // New chunk enters at the MSB end; written as a wide shift so W==N also works.
    assign w_sum_next = N'({w_res, r_sum_sh} >> W);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_carry     <= 1'b0;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum_sh    <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a_sh     <= bus.a;
                        r_b_sh     <= bus.b;
                        r_carry    <= 1'b0;
                        r_count    <= '0;
                        r_state    <= ST_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_a_sh   <= r_a_sh >> W;
                    r_b_sh   <= r_b_sh >> W;
                    r_sum_sh <= w_sum_next;
                    r_carry  <= w_cout;
                    // Published result only moves on completion so sum/cout hold during RUN.
                    if (r_count == LAST) begin
                        r_count     <= '0;
                        r_state     <= ST_DONE;
                        r_sum       <= w_sum_next;
                        r_cout      <= w_cout;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_count <= r_count + ONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_sum_chunk_sequencer.sv
// Scoreboard bench for sum_chunk_sequencer: expected sums are queued at accept
// time from a full-width reference add and compared when the result is taken.
module tb_sum_chunk_sequencer;
    import sum_pkg::*;

    localparam int N  = 128;
    localparam int CC = 16;

    typedef struct packed {
        logic [N-1:0] sum;
        logic         cout;
    } exp_t;

    logic clk;
    logic rst;
    int   totalChecks;
    int   badChecks;
    exp_t scoreboard[$];
    logic [N-1:0] lastSum;

    sum_chunk_sequencer_if #(.N(N)) bus ();

    sum_chunk_sequencer #(.N(N), .CC(CC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [N:0] observed, input logic [N:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic pushExpected(input logic [N-1:0] opA, input logic [N-1:0] opB);
        logic [N:0] full;
        exp_t       e;
        full   = {1'b0, opA} + {1'b0, opB};
        e.sum  = full[N-1:0];
        e.cout = full[N];
        scoreboard.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic applyStimulus(input logic [N-1:0] opA, input logic [N-1:0] opB);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) checkOutput("accept_timeout", 0, 1);
        bus.a        = opA;
        bus.b        = opB;
        bus.in_valid = 1'b1;
        pushExpected(opA, opB);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("busy_after_accept", bus.busy, 1);
        checkOutput("in_ready_in_run", bus.in_ready, 0);
    endtask

    // Called at a negedge; holds out_ready low for holdCycles once the result is up.
    task automatic collectResult(input int holdCycles, input bit checkLat);
        int   k;
        exp_t e;
        k = 0;
        while (!bus.out_valid && k < 100) begin
            @(negedge clk);
            k++;
            if (checkLat && k == 1) checkOutput("run_sum_retained", bus.sum, lastSum);
        end
        if (checkLat) checkOutput("latency", k, CC);
        if (scoreboard.size() == 0) begin
            checkOutput("scoreboard_empty", 0, 1);
            return;
        end
        e = scoreboard[0];
        bus.out_ready = 1'b0;
        for (int i = 0; i < holdCycles; i++) begin
            checkOutput("hold_valid", bus.out_valid, 1);
            checkOutput("hold_sum", bus.sum, e.sum);
            checkOutput("hold_cout", bus.cout, e.cout);
            checkOutput("hold_in_ready", bus.in_ready, 0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        e = scoreboard.pop_front();
        checkOutput("out_valid", bus.out_valid, 1);
        checkOutput("sum", bus.sum, e.sum);
        checkOutput("cout", bus.cout, e.cout);
        lastSum = e.sum;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput("idle_in_ready", bus.in_ready, 1);
        checkOutput("idle_out_valid", bus.out_valid, 0);
        checkOutput("idle_busy", bus.busy, 0);
    endtask

    initial begin
        logic [N-1:0] onesV;
        logic [N-1:0] opA2;
        logic [N-1:0] opB2;
        exp_t         dropped;
        int           k;

        totalChecks   = 0;
        badChecks     = 0;
        lastSum       = '0;
        onesV         = '1;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;

        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", bus.in_ready, 1);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_sum", bus.sum, 0);
        checkOutput("rst_cout", bus.cout, 0);
        checkOutput("rst_busy", bus.busy, 0);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] basic 1+1");
        applyStimulus(128'd1, 128'd1);
        collectResult(0, 1);

        $display("[TB] carry across first chunk boundary");
        applyStimulus(128'h00FF, 128'h0001);
        collectResult(0, 1);

        $display("[TB] full-width overflow cases");
        applyStimulus(onesV, 128'd1);
        collectResult(0, 1);
        applyStimulus(onesV, onesV);
        collectResult(0, 1);

        $display("[TB] backpressure");
        applyStimulus(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'h8000_0000_0000_0000_8000_0000_0000_0001);
        collectResult(5, 1);

        $display("[TB] in_valid held during RUN");
        applyStimulus(128'hDEAD_BEEF_0000_FFFF_1234_5678_9ABC_DEF0, 128'h0000_0001_FFFF_0001_0000_0000_FFFF_FFFF);
        bus.in_valid = 1'b1;
        k = 0;
        while (!bus.out_valid && k < 100) begin
            bus.a = {$urandom, $urandom, $urandom, $urandom};
            bus.b = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            k++;
        end
        checkOutput("ignore_latency", k, CC);
        opA2  = 128'h7FFF_FFFF_FFFF_FFFF_0000_0000_0000_00FF;
        opB2  = 128'h8000_0000_0000_0001_0000_0000_0000_0001;
        bus.a = opA2;
        bus.b = opB2;
        pushExpected(opA2, opB2);
        collectResult(0, 0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("second_accept_busy", bus.busy, 1);
        collectResult(0, 1);

        $display("[TB] reset mid-RUN");
        applyStimulus(onesV, 128'd1);
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort_in_ready", bus.in_ready, 1);
        checkOutput("abort_out_valid", bus.out_valid, 0);
        checkOutput("abort_sum", bus.sum, 0);
        checkOutput("abort_cout", bus.cout, 0);
        checkOutput("abort_busy", bus.busy, 0);
        if (scoreboard.size() != 0) dropped = scoreboard.pop_front();
        lastSum = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(128'd3, 128'd5);
        collectResult(0, 1);

        checkOutput("scoreboard_drained", scoreboard.size(), 0);
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
